// File: rtl/up_dn_pkg.sv
// Shared types for the up/down counter command front-end.
// Debounce state encoding and command priority (numeric value = priority).
package up_dn_pkg;

    localparam int WIDTH_DEF = 5;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_CHK = 2'd1,
        HELD      = 2'd2,
        REL_CHK   = 2'd3
    } deb_state_e;

    typedef enum logic [1:0] {
        CMD_NONE = 2'd0,
        CMD_UP   = 2'd1,
        CMD_DN   = 2'd2,
        CMD_LD   = 2'd3
    } cmd_e;

endpackage

// File: rtl/up_dn_cmd_ctrl_btn_debounce.sv
// Per-button 2-flop synchroniser, debounce FSM and (with AUTO_REPEAT_EN) repeat timer.
// press is a registered one-cycle pulse per accepted press or repeat.
module btn_debounce
    import up_dn_pkg::*;
#(
    parameter int DEB_CYCLES = 50000
`ifdef AUTO_REPEAT_EN
    ,
    parameter int RPT_DELAY  = 500000,
    parameter int RPT_PERIOD = 100000,
    parameter bit RPT_EN     = 1'b0
`endif
) (
    input  logic CLK,
    input  logic RST,
    input  logic btn,
    output logic press
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic [1:0]    sync_r;
    logic          s_s;
    deb_state_e    state_r;
    logic [CW-1:0] cnt_r;
    logic          press_r;

    // Two-flop synchroniser for the raw button level
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_r <= 2'b00;
        end else begin
            sync_r <= {sync_r[0], btn};
        end
    end

    assign s_s = sync_r[1];

    // Debounce FSM; counter stops at CNT_LAST so it can never wrap
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r <= IDLE;
            cnt_r   <= {CW{1'b0}};
            press_r <= 1'b0;
        end else begin
            press_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (s_s) begin
                        state_r <= PRESS_CHK;
                        cnt_r   <= {CW{1'b0}};
                    end
                end
                PRESS_CHK: begin
                    if (!s_s) begin
                        state_r <= IDLE;
                    end else if (cnt_r == CNT_LAST) begin
                        state_r <= HELD;
                        press_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                HELD: begin
                    if (!s_s) begin
                        state_r <= REL_CHK;
                        cnt_r   <= {CW{1'b0}};
                    end
                end
                REL_CHK: begin
                    if (s_s) begin
                        state_r <= HELD;
                    end else if (cnt_r == CNT_LAST) begin
                        state_r <= IDLE;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

`ifdef AUTO_REPEAT_EN
    localparam int RMAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);

    logic [RW-1:0] rpt_cnt_r;
    logic [RW-1:0] rpt_lim_s;
    logic          rpt_first_r;
    logic          rpt_r;

    // Repeat interval: long delay before the first repeat, shorter period afterwards
    always_comb begin
        if (rpt_first_r) begin
            rpt_lim_s = RW'(RPT_PERIOD - 1);
        end else begin
            rpt_lim_s = RW'(RPT_DELAY - 1);
        end
    end

    // Repeat timer runs only while the button stays in HELD
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rpt_cnt_r   <= {RW{1'b0}};
            rpt_first_r <= 1'b0;
            rpt_r       <= 1'b0;
        end else begin
            rpt_r <= 1'b0;
            if (RPT_EN && (state_r == HELD) && s_s) begin
                if (rpt_cnt_r == rpt_lim_s) begin
                    rpt_r       <= 1'b1;
                    rpt_cnt_r   <= {RW{1'b0}};
                    rpt_first_r <= 1'b1;
                end else begin
                    rpt_cnt_r <= rpt_cnt_r + RW'(1);
                end
            end else begin
                rpt_cnt_r   <= {RW{1'b0}};
                rpt_first_r <= 1'b0;
            end
        end
    end

    assign press = press_r | rpt_r;
`else
    assign press = press_r;
`endif

endmodule

// File: rtl/up_dn_cmd_ctrl.sv
// Command front-end for the 5-bit up/down counter: debounced buttons, arbitration, flag masking.
// Optional auto-repeat of Up/Down when AUTO_REPEAT_EN is defined.
module up_dn_cmd_ctrl
    import up_dn_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEF,
    parameter int DEB_CYCLES = 50000
`ifdef AUTO_REPEAT_EN
    ,
    parameter int RPT_DELAY  = 500000,
    parameter int RPT_PERIOD = 100000
`endif
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Btn_Up,
    input  logic             Btn_Dn,
    input  logic             Btn_Ld,
    input  logic [WIDTH-1:0] Sw_In,
    input  logic             High,
    input  logic             Low,
    output logic             Up,
    output logic             Down,
    output logic             Load,
    output logic [WIDTH-1:0] IN,
    output logic             Blocked
);

    logic             up_p_s;
    logic             dn_p_s;
    logic             ld_p_s;
    logic [WIDTH-1:0] sw_meta_r;
    logic [WIDTH-1:0] sync_sw_r;
    logic             busy_s;
    cmd_e             cmd_s;

`ifdef AUTO_REPEAT_EN
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .RPT_DELAY(RPT_DELAY), .RPT_PERIOD(RPT_PERIOD), .RPT_EN(1'b1))
        u_up (.CLK(CLK), .RST(RST), .btn(Btn_Up), .press(up_p_s));
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .RPT_DELAY(RPT_DELAY), .RPT_PERIOD(RPT_PERIOD), .RPT_EN(1'b1))
        u_dn (.CLK(CLK), .RST(RST), .btn(Btn_Dn), .press(dn_p_s));
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .RPT_DELAY(RPT_DELAY), .RPT_PERIOD(RPT_PERIOD), .RPT_EN(1'b0))
        u_ld (.CLK(CLK), .RST(RST), .btn(Btn_Ld), .press(ld_p_s));
`else
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_up (.CLK(CLK), .RST(RST), .btn(Btn_Up), .press(up_p_s));
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_dn (.CLK(CLK), .RST(RST), .btn(Btn_Dn), .press(dn_p_s));
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_ld (.CLK(CLK), .RST(RST), .btn(Btn_Ld), .press(ld_p_s));
`endif

    // Two-flop synchroniser for the switch bank
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sw_meta_r <= {WIDTH{1'b0}};
            sync_sw_r <= {WIDTH{1'b0}};
        end else begin
            sw_meta_r <= Sw_In;
            sync_sw_r <= sw_meta_r;
        end
    end

    // A command issued last cycle forces an idle gap so the counter flags can settle
    assign busy_s = Up | Down | Load;

    // Priority select Load > Down > Up; losers are dropped
    always_comb begin
        cmd_s = CMD_NONE;
        if (busy_s) begin
            cmd_s = CMD_NONE;
        end else if (ld_p_s) begin
            cmd_s = CMD_LD;
        end else if (dn_p_s) begin
            cmd_s = CMD_DN;
        end else if (up_p_s) begin
            cmd_s = CMD_UP;
        end else begin
            cmd_s = CMD_NONE;
        end
    end

    // Output registers; High/Low masking uses the flags sampled on this edge
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            Up      <= 1'b0;
            Down    <= 1'b0;
            Load    <= 1'b0;
            Blocked <= 1'b0;
            IN      <= {WIDTH{1'b0}};
        end else begin
            Up      <= 1'b0;
            Down    <= 1'b0;
            Load    <= 1'b0;
            Blocked <= 1'b0;
            case (cmd_s)
                CMD_LD: begin
                    Load <= 1'b1;
                    IN   <= sync_sw_r;
                end
                CMD_DN: begin
                    if (Low) begin
                        Blocked <= 1'b1;
                    end else begin
                        Down <= 1'b1;
                    end
                end
                CMD_UP: begin
                    if (High) begin
                        Blocked <= 1'b1;
                    end else begin
                        Up <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_up_dn_cmd_ctrl.sv
// Directed bench for up_dn_cmd_ctrl with DEB_CYCLES=4 (RPT_DELAY=20, RPT_PERIOD=8 under AUTO_REPEAT_EN).
// Raw edge sampled at edge e0 -> press pulse after e0+6 -> registered command after e0+7.
module tb_up_dn_cmd_ctrl;

    localparam int W = 5;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         Btn_Up = 1'b0;
    logic         Btn_Dn = 1'b0;
    logic         Btn_Ld = 1'b0;
    logic [W-1:0] Sw_In = 5'b00000;
    logic         High = 1'b0;
    logic         Low = 1'b0;
    logic         Up;
    logic         Down;
    logic         Load;
    logic [W-1:0] IN;
    logic         Blocked;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    int up_n = 0, dn_n = 0, ld_n = 0, blk_n = 0, viol_n = 0;
    int up_t[$];
    int dn_t[$];
    int ld_t[$];
    int blk_t[$];

    up_dn_cmd_ctrl #(
        .WIDTH(W),
        .DEB_CYCLES(4)
`ifdef AUTO_REPEAT_EN
        ,
        .RPT_DELAY(20),
        .RPT_PERIOD(8)
`endif
    ) u_dut (
        .CLK(CLK), .RST(RST), .Btn_Up(Btn_Up), .Btn_Dn(Btn_Dn), .Btn_Ld(Btn_Ld),
        .Sw_In(Sw_In), .High(High), .Low(Low), .Up(Up), .Down(Down), .Load(Load),
        .IN(IN), .Blocked(Blocked)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc++;

    // Record output pulses with their edge number and flag any illegal overlap
    always @(negedge CLK) begin
        if (!RST) begin
            if (Up)      begin up_n++;  up_t.push_back(cyc);  end
            if (Down)    begin dn_n++;  dn_t.push_back(cyc);  end
            if (Load)    begin ld_n++;  ld_t.push_back(cyc);  end
            if (Blocked) begin blk_n++; blk_t.push_back(cyc); end
            if ((int'(Up) + int'(Down) + int'(Load)) > 1 || (Blocked && (Up || Down)))
                viol_n++;
        end
    end

    task automatic check_val(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int qat(input int q[$], input int i);
        return (q.size() > i) ? q[i] : -1;
    endfunction

    // Drive a button mask for 'hold' edges, release, then let everything settle
    task automatic press(input logic [2:0] m, input int hold, output int e0);
        @(negedge CLK);
        {Btn_Ld, Btn_Dn, Btn_Up} = m;
        e0 = cyc + 1;
        repeat (hold) @(negedge CLK);
        {Btn_Ld, Btn_Dn, Btn_Up} = 3'b000;
        repeat (14) @(negedge CLK);
    endtask

    int e0, r1, b, b2, b3;
`ifdef AUTO_REPEAT_EN
    int off[6] = '{0, 20, 28, 36, 44, 52};
`endif

    initial begin
        repeat (3) @(negedge CLK);
        check_val("rst_up", int'(Up), 0);
        check_val("rst_down", int'(Down), 0);
        check_val("rst_load", int'(Load), 0);
        check_val("rst_blocked", int'(Blocked), 0);
        check_val("rst_in", int'(IN), 0);
        RST = 1'b0;
        repeat (3) @(negedge CLK);

        // Single clean Up press
        b = up_n;
        press(3'b001, 10, e0);
`ifdef AUTO_REPEAT_EN
        check_val("t1_up_count", up_n - b, 1);
`else
        check_val("t1_up_count", up_n - b, 1);
`endif
        check_val("t1_up_time", qat(up_t, b), e0 + 7);

        // Down glitch 1-0-1-0 must be rejected; a clean press afterwards has full latency
        b = dn_n;
        @(negedge CLK) Btn_Dn = 1'b1;
        @(negedge CLK) Btn_Dn = 1'b0;
        @(negedge CLK) Btn_Dn = 1'b1;
        @(negedge CLK) Btn_Dn = 1'b0;
        repeat (12) @(negedge CLK);
        check_val("t2_glitch_down", dn_n - b, 0);
        press(3'b010, 8, e0);
        check_val("t2_down_count", dn_n - b, 1);
        check_val("t2_down_time", qat(dn_t, b), e0 + 7);

        // Load and Up together: Load wins and captures the switches
        Sw_In = 5'b10110;
        b = ld_n; b2 = up_n;
        press(3'b101, 8, e0);
        check_val("t3_load_count", ld_n - b, 1);
        check_val("t3_load_time", qat(ld_t, b), e0 + 7);
        check_val("t3_in", int'(IN), 22);
        check_val("t3_up_dropped", up_n - b2, 0);

        // Up and Down together: Down wins
        b = dn_n; b2 = up_n;
        press(3'b011, 8, e0);
        check_val("t3b_down_count", dn_n - b, 1);
        check_val("t3b_up_dropped", up_n - b2, 0);

        // Flag masking
        Low = 1'b1;
        b = dn_n; b3 = blk_n;
        press(3'b010, 8, e0);
        check_val("t4_down_masked", dn_n - b, 0);
        check_val("t4_blocked_dn", blk_n - b3, 1);
        check_val("t4_blocked_time", qat(blk_t, b3), e0 + 7);
        Low = 1'b0; High = 1'b1;
        b = up_n; b3 = blk_n;
        press(3'b001, 8, e0);
        check_val("t4_up_masked", up_n - b, 0);
        check_val("t4_blocked_up", blk_n - b3, 1);
        High = 1'b0;

        // Reset mid PRESS_CHK with Btn_Up held
        b = up_n;
        @(negedge CLK) Btn_Up = 1'b1;
        repeat (4) @(negedge CLK);
        #2 RST = 1'b1;
        #1;
        check_val("t5_in_async_clr", int'(IN), 0);
        check_val("t5_up_async", int'(Up), 0);
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        r1 = cyc + 1;
        repeat (10) @(negedge CLK);
        Btn_Up = 1'b0;
        repeat (14) @(negedge CLK);
        check_val("t5_up_count", up_n - b, 1);
        check_val("t5_up_time", qat(up_t, b), r1 + 7);

`ifdef AUTO_REPEAT_EN
        // Auto-repeat while Up is held for 60 edges
        b = up_n;
        press(3'b001, 60, e0);
        check_val("t6_up_count", up_n - b, 6);
        for (int i = 0; i < 6; i++)
            check_val($sformatf("t6_up_time%0d", i), qat(up_t, b + i), e0 + 7 + off[i]);
`endif

        check_val("onehot_violations", viol_n, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
